// File: rtl/ptimer_pkg.sv
// ptimer_pkg
//   Shared definitions for the dual-channel pulse timer: FSM state encoding
//   and the two-bit compare result codes driven on the cmp output.
package ptimer_pkg;

  typedef enum logic {
    COLLECT = 1'b0,   // gathering one operand from each channel
    PULSE   = 1'b1    // out high, counting down the selected length
  } state_t;

  typedef logic [1:0] cmp_t;

  localparam cmp_t CMP_NONE = 2'b00;  // no compare since reset
  localparam cmp_t CMP_LT   = 2'b01;  // B < A
  localparam cmp_t CMP_EQ   = 2'b10;  // B == A
  localparam cmp_t CMP_GT   = 2'b11;  // B > A

endpackage

// File: rtl/mag_cmp.sv
// mag_cmp
//   Combinational magnitude comparator built on a W+1 bit subtractor (A-B)
//   plus a zero detect on the difference.
//   Parameters: W operand width, SIGNED 0 = unsigned, 1 = two's complement.
//   Ports:
//     a, b    : input  [W-1:0] operands
//     b_gt_a  : output         B > A
//     b_eq_a  : output         B == A
module mag_cmp #(
  parameter int W      = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         b_gt_a,
  output logic         b_eq_a
);

  logic [W-1:0] a_k;
  logic [W-1:0] b_k;
  logic [W:0]   diff;

  // Flipping the sign bit maps two's complement onto offset binary, so one
  // unsigned subtractor serves both modes.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    a_k = a;
    b_k = b;
    if (SIGNED) begin
      a_k[W-1] = ~a[W-1];
      b_k[W-1] = ~b[W-1];
    end
  end

  assign diff   = {1'b0, a_k} - {1'b0, b_k};
  assign b_gt_a = diff[W];               // borrow out: A < B
  assign b_eq_a = (diff[W-1:0] == '0);

endmodule

// File: rtl/dual_channel_pulse_timer.sv
// dual_channel_pulse_timer
//   Collects one operand from each of two producers over independent
//   active-low dav_/rfd handshakes, compares B against A and drives out high
//   for LEN_GT / LEN_EQ / LEN_LT cycles according to the result.
//   Parameters: W, SIGNED, LEN_GT, LEN_EQ, LEN_LT, CW (pulse counter width).
//   Ports:
//     clock          : system clock, all activity on posedge
//     reset_         : synchronous reset, active low
//     davA_, davB_   : channel data valid, active low
//     rfdA, rfdB     : channel ready-for-data, active high (registered)
//     dataA, dataB   : channel operands [W-1:0]
//     out            : timed pulse (registered)
//     cmp            : last compare result, see ptimer_pkg codes (registered)
module dual_channel_pulse_timer
  import ptimer_pkg::*;
#(
  parameter int W      = 8,
  parameter bit SIGNED = 1'b0,
  parameter int LEN_GT = 12,
  parameter int LEN_EQ = 12,
  parameter int LEN_LT = 6,
  parameter int CW     = 8
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         davA_,
  output logic         rfdA,
  input  logic [W-1:0] dataA,
  input  logic         davB_,
  output logic         rfdB,
  input  logic [W-1:0] dataB,
  output logic         out,
  output logic [1:0]   cmp
);

  if (W < 2) begin : g_bad_width
    $error("dual_channel_pulse_timer: W must be at least 2");
  end
  if (LEN_GT < 1 || LEN_GT >= (1 << CW) ||
      LEN_EQ < 1 || LEN_EQ >= (1 << CW) ||
      LEN_LT < 1 || LEN_LT >= (1 << CW)) begin : g_bad_len
    $error("dual_channel_pulse_timer: every LEN_* must be in 1..2**CW-1");
  end

  state_t        state;
  logic [W-1:0]  reg_a;
  logic [W-1:0]  reg_b;
  logic          got_a;
  logic          got_b;
  logic [CW-1:0] count;

  logic          b_gt_a;
  logic          b_eq_a;
  cmp_t          cmp_code;
  logic [CW-1:0] pulse_len;

  // Compare works on the captured operands, never on the live inputs.
  mag_cmp #(
    .W      (W),
    .SIGNED (SIGNED)
  ) u_mag_cmp (
    .a      (reg_a),
    .b      (reg_b),
    .b_gt_a (b_gt_a),
    .b_eq_a (b_eq_a)
  );

  always_comb begin
    cmp_code  = CMP_LT;
    pulse_len = CW'(LEN_LT);
    if (b_eq_a) begin
      cmp_code  = CMP_EQ;
      pulse_len = CW'(LEN_EQ);
    end else if (b_gt_a) begin
      cmp_code  = CMP_GT;
      pulse_len = CW'(LEN_GT);
    end
  end

  // NOTE: the operand registers are deliberately left out of reset; they are
  // only read after a fresh capture sets the matching got flag.
  always_ff @(posedge clock) begin
    if (reg_a_load()) reg_a <= dataA;
    if (reg_b_load()) reg_b <= dataB;
  end

  function automatic logic reg_a_load();
    return reset_ && (state == COLLECT) && rfdA && !davA_;
  endfunction

  function automatic logic reg_b_load();
    return reset_ && (state == COLLECT) && rfdB && !davB_;
  endfunction

  // NOTE: all state below uses non-blocking assignments so every register
  // sees the pre-edge value of every other register.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state <= COLLECT;
      rfdA  <= 1'b1;
      rfdB  <= 1'b1;
      got_a <= 1'b0;
      got_b <= 1'b0;
      out   <= 1'b0;
      cmp   <= CMP_NONE;
      count <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (rfdA && !davA_) begin
            got_a <= 1'b1;
            rfdA  <= 1'b0;
          end
          if (rfdB && !davB_) begin
            got_b <= 1'b1;
            rfdB  <= 1'b0;
          end
          // Both operands held and both producers have released dav_.
          // Captures and exit are mutually exclusive: capture needs rfd=1,
          // which implies the matching got flag is still 0.
          if (got_a && got_b && davA_ && davB_) begin
            count <= pulse_len;
            cmp   <= cmp_code;
            out   <= 1'b1;
            state <= PULSE;
          end
        end
        PULSE: begin
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            out   <= 1'b0;
            rfdA  <= 1'b1;
            rfdB  <= 1'b1;
            got_a <= 1'b0;
            got_b <= 1'b0;
            state <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_dual_channel_pulse_timer.sv
// tb_dual_channel_pulse_timer
//   Drives one shared stimulus stream into an unsigned and a signed instance.
//   Expected compare code and pulse length are queued per instance when a
//   transaction is driven and popped when that instance's pulse appears.
module tb_dual_channel_pulse_timer;

  logic       clock = 1'b0;
  logic       reset_;
  logic       davA_, davB_;
  logic [7:0] dataA, dataB;

  logic       rfdA_u, rfdB_u, out_u;
  logic [1:0] cmp_u;
  logic       rfdA_s, rfdB_s, out_s;
  logic [1:0] cmp_s;

  always #5 clock = ~clock;

  dual_channel_pulse_timer #(
    .W(8), .SIGNED(1'b0), .LEN_GT(12), .LEN_EQ(12), .LEN_LT(6), .CW(8)
  ) u_dut_u (
    .clock (clock), .reset_ (reset_),
    .davA_ (davA_), .rfdA (rfdA_u), .dataA (dataA),
    .davB_ (davB_), .rfdB (rfdB_u), .dataB (dataB),
    .out   (out_u), .cmp  (cmp_u)
  );

  dual_channel_pulse_timer #(
    .W(8), .SIGNED(1'b1), .LEN_GT(12), .LEN_EQ(12), .LEN_LT(6), .CW(8)
  ) u_dut_s (
    .clock (clock), .reset_ (reset_),
    .davA_ (davA_), .rfdA (rfdA_s), .dataA (dataA),
    .davB_ (davB_), .rfdB (rfdB_s), .dataB (dataB),
    .out   (out_s), .cmp  (cmp_s)
  );

  typedef struct {
    logic [1:0] code;
    int         len;
  } exp_t;

  exp_t q_u[$];
  exp_t q_s[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input bit sgn);
    exp_t e;
    int   ai, bi;
    if (sgn) begin
      ai = int'($signed(a));
      bi = int'($signed(b));
    end else begin
      ai = int'(a);
      bi = int'(b);
    end
    if (bi > ai)       e = '{2'b11, 12};
    else if (bi == ai) e = '{2'b10, 12};
    else               e = '{2'b01, 6};
    return e;
  endfunction

  // Pulse monitors: measure each pulse and compare against the queue head.
  logic prev_u = 1'b0, prev_s = 1'b0;
  int   run_u = 0, run_s = 0;
  exp_t cur_u, cur_s;

  always @(negedge clock) begin
    if (mon_en) begin
      if (out_u && !prev_u) begin
        run_u = 1;
        if (q_u.size() == 0) begin
          check("u_unexpected_pulse", 1, 0);
          cur_u = '{2'b00, 0};
        end else cur_u = q_u.pop_front();
        check("u_cmp", 32'(cmp_u), 32'(cur_u.code));
        check("u_rfd_low_in_pulse", {rfdA_u, rfdB_u}, 0);
      end else if (out_u) begin
        run_u++;
      end else if (prev_u) begin
        check("u_pulse_len", run_u, cur_u.len);
        check("u_rfd_after_pulse", {rfdA_u, rfdB_u}, 2'b11);
      end
    end
    prev_u = out_u;
  end

  always @(negedge clock) begin
    if (mon_en) begin
      if (out_s && !prev_s) begin
        run_s = 1;
        if (q_s.size() == 0) begin
          check("s_unexpected_pulse", 1, 0);
          cur_s = '{2'b00, 0};
        end else cur_s = q_s.pop_front();
        check("s_cmp", 32'(cmp_s), 32'(cur_s.code));
        check("s_rfd_low_in_pulse", {rfdA_s, rfdB_s}, 0);
      end else if (out_s) begin
        run_s++;
      end else if (prev_s) begin
        check("s_pulse_len", run_s, cur_s.len);
        check("s_rfd_after_pulse", {rfdA_s, rfdB_s}, 2'b11);
      end
    end
    prev_s = out_s;
  end

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(negedge clock);
      idle = !out_u && !out_s && rfdA_u && rfdB_u && rfdA_s && rfdB_s;
    end
    if (!idle) check("idle_timeout", 1, 0);
    @(negedge clock);
  endtask

  // One transaction: davA_ low for ha cycles starting at cycle da, same for
  // B. Data is only valid on the first low cycle; later it is scrambled to
  // show that a captured channel ignores its data lines.
  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input int da, input int db, input int ha, input int hb);
    int e;
    e = (da + ha > db + hb) ? da + ha : db + hb;
    q_u.push_back(model(a, b, 1'b0));
    q_s.push_back(model(a, b, 1'b1));
    for (int t = 0; t <= e; t++) begin
      @(negedge clock);
      check("no_early_pulse", {out_u, out_s}, 0);
      if (t > da) check("rfdA_low_after_capture", {rfdA_u, rfdA_s}, 0);
      if (t > db) check("rfdB_low_after_capture", {rfdB_u, rfdB_s}, 0);
      davA_ = !(t >= da && t < da + ha);
      davB_ = !(t >= db && t < db + hb);
      dataA = (t == da) ? a : 8'($urandom);
      dataB = (t == db) ? b : 8'($urandom);
    end
    @(negedge clock);
    check("pulse_starts_after_release", {out_u, out_s}, 2'b11);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_ = 1'b0;
    davA_  = 1'b1;
    davB_  = 1'b1;
    dataA  = '0;
    dataB  = '0;
    repeat (2) @(negedge clock);
    check("reset_out", {out_u, out_s}, 0);
    check("reset_rfd", {rfdA_u, rfdB_u, rfdA_s, rfdB_s}, 4'b1111);
    check("reset_cmp", {cmp_u, cmp_s}, 0);
    reset_ = 1'b1;
    @(negedge clock);
    mon_en = 1'b1;

    drive(8'h10, 8'h20, 0, 0, 1, 1);   // simultaneous, B>A
    drive(8'h33, 8'h33, 0, 5, 1, 1);   // staggered, equal
    drive(8'hF0, 8'h0F, 0, 0, 1, 1);   // unsigned B<A, signed B>A
    drive(8'h80, 8'h7F, 1, 0, 1, 2);   // -128 vs 127
    drive(8'h44, 8'h40, 0, 2, 10, 1);  // davA_ held low 10 cycles
    for (int i = 0; i < 4; i++)
      drive(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
            int'($urandom_range(1, 3)));

    // Reset in the middle of a pulse.
    mon_en = 1'b0;
    @(negedge clock);
    davA_ = 1'b0; davB_ = 1'b0; dataA = 8'h10; dataB = 8'h20;
    @(negedge clock);
    davA_ = 1'b1; davB_ = 1'b1;
    repeat (4) @(negedge clock);
    check("pre_reset_pulse", {out_u, out_s}, 2'b11);
    reset_ = 1'b0;
    @(negedge clock);
    check("midpulse_reset_out", {out_u, out_s}, 0);
    check("midpulse_reset_rfd", {rfdA_u, rfdB_u, rfdA_s, rfdB_s}, 4'b1111);
    check("midpulse_reset_cmp", {cmp_u, cmp_s}, 0);
    @(negedge clock);
    reset_ = 1'b1;
    @(negedge clock);
    check("post_reset_idle", {out_u, out_s, cmp_u, cmp_s}, 0);
    mon_en = 1'b1;

    drive(8'h05, 8'h03, 0, 0, 1, 1);   // recovery after reset, B<A

    check("queues_drained", q_u.size() + q_s.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
